dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 4, max consecutive grants to one requester while the other waits (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  access request, bit n = requester n (0 = CPU load/store port, 1 = DMA/debug port).
REQ-005 we  input  2  write-enable per requester, valid while req[n]=1.
REQ-006 addr  input  64  byte address, requester n on [32n+31:32n].
REQ-007 wdata  input  64  write data, requester n on [32n+31:32n].
REQ-008 gnt  output  2  one-hot-or-zero; gnt[n]=1 means requester n's access executes this cycle.
REQ-009 rvalid  output  2  rvalid[n] pulses one cycle after a granted read by requester n.
REQ-010 rdata  output  32  registered read data, qualified by rvalid.
REQ-011 mem_we  output  1  write strobe to the single-port data memory.
REQ-012 mem_a  output  32  memory address.
REQ-013 mem_wd  output  32  memory write data.
REQ-014 mem_rd  input  32  memory read data, combinational from mem_a.

Function
REQ-015 State: owner (NONE/R0/R1), burst counter cnt (0..MAX_BURST), last-served pointer lsp (1 bit).
REQ-016 gnt is combinational from current req and state; at most one bit set per cycle.
REQ-017 owner NONE: single requester wins; both requesting -> requester !lsp wins.
REQ-018 owner requesting and cnt<MAX_BURST -> owner keeps grant, cnt increments.
REQ-019 owner requesting, cnt==MAX_BURST, other requesting -> grant switches to other, cnt=1, owner=other.
REQ-020 owner requesting, cnt==MAX_BURST, other idle -> owner keeps grant, cnt restarts at 1.
REQ-021 owner not requesting -> other granted if requesting (cnt=1), else owner=NONE, cnt=0, gnt=0.
REQ-022 lsp updates to granted requester index on every grant cycle; holds otherwise.
REQ-023 Starvation bound: a continuously requesting requester is granted within MAX_BURST cycles of raising req.
REQ-024 Granted cycle: mem_a/mem_wd = granted requester's addr/wdata; mem_we = its we.
REQ-025 No grant: mem_we=0, mem_a=0, mem_wd=0.
REQ-026 Granted read (we=0): rdata <= mem_rd and rvalid[n] <= 1 at that edge; rvalid high exactly one cycle per read.
REQ-027 Granted write: no rvalid; rdata holds previous value.
REQ-028 Back-to-back reads give one rvalid per read, in grant order, no bubbles.
REQ-029 Ungranted requester must hold req/we/addr/wdata stable until granted; arbiter does not check.
REQ-030 Deasserting req before grant withdraws request with no side effect.

Reset
REQ-031 reset=1 at an edge: owner=NONE, cnt=0, lsp=1, rvalid=0, rdata=0.
REQ-032 While reset=1: gnt=0, mem_we=0, mem_a=0, mem_wd=0, regardless of req.
REQ-033 Reset mid-burst or mid-read: pending rvalid is cancelled; first post-reset tie goes to requester 0.

Verification
REQ-034 Reset, then req=2'b11 both reads -> gnt=01 first cycle, rvalid=01 next cycle with rdata=mem[addr0].
REQ-035 MAX_BURST=4, req=2'b11 held -> gnt pattern 01,01,01,01,10,10,10,10,01...
REQ-036 Only req[0] held 10 cycles -> gnt=01 every cycle, no gap at cnt wrap.
REQ-037 r0 writes 0xDEADBEEF to 0x40, then r1 reads 0x40 -> mem_we=1 one cycle, rvalid=10 with rdata=0xDEADBEEF.
REQ-038 reset asserted during r1 burst with read in flight -> rvalid=00 next cycle, gnt=00 during reset, then tie grants r0.
REQ-039 r1 raises req for 1 cycle without grant, drops it -> no gnt[1], no rvalid[1], no memory write.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Bounded-burst ownership with round-robin tie break; reads return one cycle later.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] MAXC = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    R0   = 2'd1,
    R1   = 2'd2
  } owner_t;

  owner_t     owner, owner_n;
  logic [3:0] cnt, cnt_n;
  logic       lsp, lsp_n;

  logic       own_idx;
  logic       own_req;
  logic       oth_req;
  logic       at_max;
  logic       keep;
  logic       hand;
  logic       sel;
  logic       any_gnt;
  logic [1:0] rd_hit;

  assign own_idx = (owner == R1);
  assign own_req = req[own_idx];
  assign oth_req = req[~own_idx];
  assign at_max  = (cnt >= MAXC);

  // Owner stays while under its burst budget, or when nobody else wants in.
  assign keep = own_req && (!at_max || !oth_req);
  assign hand = !keep && oth_req;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      unique case (owner)
        NONE: begin
          unique case (1'b1)
            (req == 2'b11): gnt = lsp ? 2'b01 : 2'b10;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = 2'b00;
          endcase
        end
        default: begin
          unique case (1'b1)
            keep:    gnt = own_idx ? 2'b10 : 2'b01;
            hand:    gnt = own_idx ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
          endcase
        end
      endcase
    end
  end

  assign any_gnt = |gnt;
  assign sel     = gnt[1];

  always_comb begin
    owner_n = owner;
    cnt_n   = cnt;
    lsp_n   = lsp;
    unique case (1'b1)
      any_gnt: begin
        owner_n = sel ? R1 : R0;
        lsp_n   = sel;
        if ((owner_n == owner) && !at_max)
          cnt_n = cnt + 4'd1;
        else
          cnt_n = 4'd1;
      end
      default: begin
        owner_n = NONE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = 32'h0;
    mem_wd = 32'h0;
    if (any_gnt) begin
      mem_we = we[sel];
      mem_a  = sel ? addr[63:32]  : addr[31:0];
      mem_wd = sel ? wdata[63:32] : wdata[31:0];
    end
  end

  assign rd_hit = gnt & ~we;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= NONE;
      cnt    <= 4'd0;
      lsp    <= 1'b1;
      rvalid <= 2'b00;
      rdata  <= 32'h0;
    end else begin
      owner  <= owner_n;
      cnt    <= cnt_n;
      lsp    <= lsp_n;
      rvalid <= rd_hit;
      if (|rd_hit)
        rdata <= mem_rd;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_rv_onehot:  assert property (@(posedge clk) $onehot0(rvalid));
  a_cnt_bound:  assert property (@(posedge clk) cnt <= MAXC);

endmodule
